// File: rtl/cmp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cmp_pkg
//  Purpose  : Shared constants for the serial word comparator:
//             the FSM state encoding and the slice (nibble) width.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package cmp_pkg;

  // Width of one magnitude slice.
  localparam int NIBBLE_W = 4;

  // FSM state encoding.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

endpackage : cmp_pkg
`default_nettype wire

// File: rtl/nibble_mag_cmp.sv
`default_nettype none
// ============================================================================
//  Module   : nibble_mag_cmp
//  Purpose  : Combinational unsigned magnitude compare of one nibble.
//  Ports    : a, b   in  NIBBLE_W  operand slices
//             gt     out 1         a >  b
//             eq     out 1         a == b
//             lt     out 1         a <  b
//  Revision : 1.0  initial release
// ============================================================================
module nibble_mag_cmp
  import cmp_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  output logic                gt,
  output logic                eq,
  output logic                lt
);

  assign gt = (a >  b);
  assign eq = (a == b);
  assign lt = (a <  b);

endmodule : nibble_mag_cmp
`default_nettype wire

// File: rtl/serial_word_comparator.sv
`default_nettype none
// ============================================================================
//  Module   : serial_word_comparator
//  Purpose  : Compares two WIDTH-bit unsigned operands one nibble per cycle,
//             most significant nibble first, stopping at the first unequal
//             nibble. A single 4-bit slice is time-shared across the word.
//  Ports    : clk           in   1      rising-edge clock
//             rst_n         in   1      asynchronous active-low reset
//             start_valid   in   1      a_in/b_in valid
//             start_ready   out  1      block can accept operands
//             a_in, b_in    in   WIDTH  unsigned operands
//             result_valid  out  1      result flags valid
//             result_ready  in   1      consumer accepts result
//             a_greater     out  1      A >  B
//             a_equal       out  1      A == B
//             a_less        out  1      A <  B
//             nibbles_used  out  CW     nibbles examined (1..NIB)
//  Revision : 1.0  initial release
// ============================================================================
module serial_word_comparator
  import cmp_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int NIB   = WIDTH / NIBBLE_W,
  localparam int CW    = $clog2(NIB + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             a_greater,
  output logic             a_equal,
  output logic             a_less,
  output logic [CW-1:0]    nibbles_used
);

  // Nibble index width; NIB >= 2 so this is at least 1.
  localparam int IW = $clog2(NIB);

  logic [1:0]          state_q, state_d;
  logic [WIDTH-1:0]    a_q, a_d;
  logic [WIDTH-1:0]    b_q, b_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                gt_q, gt_d;
  logic                eq_q, eq_d;
  logic                lt_q, lt_d;
  logic [CW-1:0]       used_q, used_d;

  logic [NIBBLE_W-1:0] nib_a;
  logic [NIBBLE_W-1:0] nib_b;
  logic                slice_gt;
  logic                slice_eq;
  logic                slice_lt;

  // The single shared slice sees the nibble currently selected by idx.
  assign nib_a = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
  assign nib_b = b_q[idx_q*NIBBLE_W +: NIBBLE_W];

  nibble_mag_cmp u_slice (
    .a  (nib_a),
    .b  (nib_b),
    .gt (slice_gt),
    .eq (slice_eq),
    .lt (slice_lt)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    gt_d    = gt_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    used_d  = used_q;

    case (state_q)
      S_IDLE: begin
        // start_ready is high throughout IDLE, so start_valid alone accepts.
        if (start_valid) begin
          a_d     = a_in;
          b_d     = b_in;
          idx_d   = IW'(NIB - 1);
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (slice_gt || slice_lt) begin
          // First differing nibble decides the whole word.
          gt_d    = slice_gt;
          lt_d    = slice_lt;
          eq_d    = 1'b0;
          used_d  = cnt_q + CW'(1);
          state_d = S_DONE;
        end else if (slice_eq && (idx_q == '0)) begin
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          eq_d    = 1'b1;
          used_d  = CW'(NIB);
          state_d = S_DONE;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end

      S_DONE: begin
        if (result_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      used_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      used_q  <= used_d;
    end
  end

  // Handshake outputs decode directly from the registered state.
  assign start_ready  = (state_q == S_IDLE);
  assign result_valid = (state_q == S_DONE);
  assign a_greater    = gt_q;
  assign a_equal      = eq_q;
  assign a_less       = lt_q;
  assign nibbles_used = used_q;

endmodule : serial_word_comparator
`default_nettype wire

// File: tb/tb_serial_word_comparator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_word_comparator
//  Purpose  : Directed self-checking bench for serial_word_comparator, WIDTH=16.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_word_comparator;

  localparam int WIDTH = 16;
  localparam int CW    = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start_valid = 1'b0;
  logic             start_ready;
  logic [WIDTH-1:0] a_in = '0;
  logic [WIDTH-1:0] b_in = '0;
  logic             result_valid;
  logic             result_ready = 1'b0;
  logic             a_greater;
  logic             a_equal;
  logic             a_less;
  logic [CW-1:0]    nibbles_used;

  int checks   = 0;
  int failures = 0;

  serial_word_comparator #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .a_in         (a_in),
    .b_in         (b_in),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .a_greater    (a_greater),
    .a_equal      (a_equal),
    .a_less       (a_less),
    .nibbles_used (nibbles_used)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(input string tag, input logic g, input logic e,
                             input logic l, input logic [CW-1:0] n);
    chk({tag, "_gt"},   {31'd0, a_greater}, {31'd0, g});
    chk({tag, "_eq"},   {31'd0, a_equal},   {31'd0, e});
    chk({tag, "_lt"},   {31'd0, a_less},    {31'd0, l});
    chk({tag, "_used"}, {29'd0, nibbles_used}, {29'd0, n});
  endtask

  // Accept one pair; afterwards the block is in RUN (start_valid dropped).
  task automatic accept(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    chk({tag, "_ready"}, {31'd0, start_ready}, 32'd1);
    a_in        = a;
    b_in        = b;
    start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    a_in        = '0;
    b_in        = '0;
  endtask

  // Count cycles after the accept edge until result_valid; bounded.
  task automatic wait_result(input string tag, input int exp_k);
    int k;
    k = 0;
    while (!result_valid && k < 20) begin
      step();
      k++;
    end
    chk({tag, "_latency"}, k, exp_k);
  endtask

  task automatic release_result(input string tag);
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    chk({tag, "_rv_drop"}, {31'd0, result_valid}, 32'd0);
    chk({tag, "_idle"},    {31'd0, start_ready},  32'd1);
  endtask

  task automatic run_pair(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic g, input logic e, input logic l, input int k);
    accept(tag, a, b);
    wait_result(tag, k);
    chk_outputs(tag, g, e, l, CW'(k));
    release_result(tag);
  endtask

  initial begin
    // 1. Reset
    a_in        = 16'hFFFF;
    b_in        = 16'h0001;
    start_valid = 1'b1;
    repeat (3) step();
    chk("rst_rv", {31'd0, result_valid}, 32'd0);
    chk_outputs("rst", 1'b0, 1'b0, 1'b0, 3'd0);
    start_valid = 1'b0;
    rst_n       = 1'b1;
    step();
    chk("rst_ready", {31'd0, start_ready}, 32'd1);
    chk("rst_rv2",   {31'd0, result_valid}, 32'd0);

    // 2. Equal operands: all four nibbles examined
    run_pair("eq", 16'h1234, 16'h1234, 1'b0, 1'b1, 1'b0, 4);

    // 4. Less at the last nibble, greater at the second nibble
    run_pair("lt", 16'h5A3C, 16'h5A3D, 1'b0, 1'b0, 1'b1, 4);
    run_pair("gt2", 16'h0F00, 16'h0E99, 1'b1, 1'b0, 1'b0, 2);

    // 3. Greater on the first nibble
    accept("gt1", 16'h9000, 16'h6FFF);
    wait_result("gt1", 1);
    chk_outputs("gt1", 1'b1, 1'b0, 1'b0, 3'd1);

    // 5. Back-pressure: result held, new operands offered but not taken
    a_in        = 16'h0F00;
    b_in        = 16'h0E99;
    start_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_rv",    {31'd0, result_valid}, 32'd1);
      chk("hold_ready", {31'd0, start_ready},  32'd0);
      chk_outputs("hold", 1'b1, 1'b0, 1'b0, 3'd1);
    end
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    chk("bp_rv_drop", {31'd0, result_valid}, 32'd0);
    chk("bp_idle",    {31'd0, start_ready},  32'd1);
    step();
    chk("bp_accepted", {31'd0, start_ready}, 32'd0);
    start_valid = 1'b0;
    a_in        = '0;
    b_in        = '0;
    wait_result("bp", 2);
    chk_outputs("bp", 1'b1, 1'b0, 1'b0, 3'd2);
    release_result("bp");

    // 6. Reset two cycles into a comparison aborts it
    accept("abort", 16'h1111, 16'h1112);
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("abort_rv",    {31'd0, result_valid}, 32'd0);
    chk_outputs("abort", 1'b0, 1'b0, 1'b0, 3'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("abort_ready", {31'd0, start_ready}, 32'd1);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
        step();
        if (result_valid) seen++;
      end
      chk("abort_no_result", seen, 0);
    end
    run_pair("post", 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the bench always ends on its own.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_serial_word_comparator
`default_nettype wire
